// File: rtl/counter4_up_pkg.sv
// counter4_up_pkg: shared width constant, count type and next-count function
// for the counter4_up sequence generator.
package counter4_up_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

  // Next count value. Priority is clr > load > en. A load above max_val
  // saturates, and an enabled increment past max_val wraps to zero.
  // Integer arguments let one function serve any WIDTH/MAX_VAL instance.
  function automatic int next_count(
    input int   cur,
    input int   max_val,
    input logic clr,
    input logic load,
    input int   load_val,
    input logic en
  );
    if (clr)  return 0;
    if (load) return (load_val > max_val) ? max_val : load_val;
    if (en)   return (cur >= max_val) ? 0 : cur + 1;
    return cur;
  endfunction

endpackage

// File: rtl/counter4_up.sv
// counter4_up: free-running up-counter that wraps after MAX_VAL, with
// synchronous clear and a terminal-count flag.
// Optional macro COUNTER4_UP_LOAD_EN adds a saturating parallel load
// (ports load / load_val).
module counter4_up
  import counter4_up_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int MAX_VAL = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
`ifdef COUNTER4_UP_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] count_d;

`ifdef COUNTER4_UP_LOAD_EN
  assign load_i     = load;
  assign load_val_i = load_val;
`else
  // Without the load feature the load path is tied off and folds away.
  assign load_i     = 1'b0;
  assign load_val_i = '0;
`endif

  // Next-state selection; all wrap/saturate rules live in the package.
  always_comb begin
    count_d = count;
    count_d = WIDTH'(next_count(int'(count), MAX_VAL, clr, load_i,
                                int'(load_val_i), en));
  end

  // Count register; reset clears it asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= '0;
    else       count <= count_d;
  end

  // Terminal count follows the registered value only, not en.
  assign tc = (count == WIDTH'(MAX_VAL));

endmodule

// File: tb/tb_counter4_up.sv
// tb_counter4_up: directed test of counter4_up with a scoreboard queue.
// Stimulus pushes expected {count, tc}; a monitor pops and compares.
module tb_counter4_up;

`ifdef COUNTER4_UP_LOAD_EN
  localparam int MAXV = 10;
`else
  localparam int MAXV = 15;
`endif

  logic       clk = 1'b0;
  logic       reset, en, clr;
  logic [3:0] count;
  logic       tc;
`ifdef COUNTER4_UP_LOAD_EN
  logic       load;
  logic [3:0] load_val;
`endif

  counter4_up #(.WIDTH(4), .MAX_VAL(MAXV)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
`ifdef COUNTER4_UP_LOAD_EN
    .load     (load),
    .load_val (load_val),
`endif
    .count    (count),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] c;
    logic       t;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   push_cnt = 0;
  int   n_chk    = 0;
  int   n_pass   = 0;
  bit   stim_done = 1'b0;

  task automatic expect_out(input int c, input bit t, input string nm);
    exp_t e;
    e.c  = 4'(c);
    e.t  = t;
    e.nm = nm;
    q.push_back(e);
    push_cnt++;
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares DUT output whenever new expectations are queued.
  initial begin
    forever begin
      @(push_cnt);
      while (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        n_chk++;
        if (count === e.c && tc === e.t) n_pass++;
        else $display("FAIL %s: got count=%0d tc=%b, want count=%0d tc=%b",
                      e.nm, count, tc, e.c, e.t);
      end
    end
  end

  // Stimulus.
  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0;
`ifdef COUNTER4_UP_LOAD_EN
    load = 1'b0; load_val = 4'd0;
`endif
    #1;
    expect_out(0, 0, "reset_state");

    // 1: reset held for two edges with en high, then count 1..8.
    en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      expect_out(0, 0, "hold_in_reset");
    end
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      expect_out(i, 0, "count_after_reset");
    end

    // 3: asynchronous reset between edges at the stop value 8.
    #2 reset = 1'b1;
    #1;
    expect_out(0, 0, "async_reset_no_edge");
    step();
    expect_out(0, 0, "async_reset_held");
    reset = 1'b0;
    step();
    expect_out(1, 0, "resume_after_async");

    // 2: 17 enabled edges from zero, through the terminal value and wrap.
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    expect_out(0, 0, "restart_zero");
    for (int i = 1; i <= 17; i++) begin
      step();
      expect_out(i % (MAXV + 1), (i % (MAXV + 1)) == MAXV, "wrap_seq");
    end

    // tc holds with en low while parked on the terminal value.
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int i = 1; i <= MAXV; i++) step();
    en = 1'b0;
    step();
    expect_out(MAXV, 1, "tc_with_en_low");
    en = 1'b1;
    step();
    expect_out(0, 0, "wrap_after_hold");

    // 4: park at 5 with en low for three edges, then advance to 6.
    for (int i = 1; i <= 5; i++) step();
    expect_out(5, 0, "reach_5");
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out(5, 0, "hold_en_low");
    end
    en = 1'b1;
    step();
    expect_out(6, 0, "resume_to_6");

    // 5: clear at 9 with en high, then count again; clear with en low.
    for (int i = 7; i <= 9; i++) step();
    expect_out(9, 0, "reach_9");
    clr = 1'b1;
    step();
    expect_out(0, 0, "clr_with_en");
    clr = 1'b0;
    step();
    expect_out(1, 0, "count_after_clr");
    clr = 1'b1; en = 1'b0;
    step();
    expect_out(0, 0, "clr_en_low");
    clr = 1'b0; en = 1'b1;

`ifdef COUNTER4_UP_LOAD_EN
    // 6: load in range, saturating load, wrap after saturation.
    load = 1'b1; load_val = 4'd7;
    step();
    expect_out(7, 0, "load_7");
    load_val = 4'd14;
    step();
    expect_out(10, 1, "load_saturate");
    load = 1'b0;
    step();
    expect_out(0, 0, "wrap_after_load");
    load = 1'b1; clr = 1'b1; load_val = 4'd3;
    step();
    expect_out(0, 0, "clr_over_load");
    load = 1'b0; clr = 1'b0;
`endif

    #3;
    stim_done = 1'b1;
  end

  // End of run: make sure every expectation was consumed, then summarise.
  initial begin
    fork
      wait (stim_done);
      #5000;
    join_any
    disable fork;
    n_chk++;
    if (stim_done && q.size() == 0) n_pass++;
    else $display("FAIL drain: done=%b pending=%0d, want done=1 pending=0",
                  stim_done, q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
